fft_iter_core: RTL and testbench

Parametrised iterative radix-2 DIT FFT of 2^STAGES complex points. It succeeds the fixed 16-point parallel FFT16_top with serial streaming I/O, valid/ready handshakes, a configurable point count, and selectable per-stage scaling with saturation. A single time-multiplexed butterfly works in place on an internal register buffer. The twiddle ROM is external: the core drives a twiddle index and receives the coefficient combinationally.

---
 rtl/fft_iter_if.sv | 56 +++++
 rtl/fft_iter_core.sv | 251 +++++++++++++++++++++++++
 tb/tb_fft_iter_core.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_iter_if.sv
`default_nettype none
// ============================================================================
//  Module   : fft_iter_if
//  Purpose  : Streaming sample input, twiddle ROM lookup and bin output
//             bundle for the iterative FFT core.
//  Revision : 1.0  initial release
// ============================================================================
interface fft_iter_if #(
    parameter int N      = 16,
    parameter int STAGES = 4
);
    // sample input stream
    logic              i_in_valid;
    logic              o_in_ready;
    logic [N-1:0]      i_in_re;
    logic [N-1:0]      i_in_im;

    // external twiddle ROM, answered combinationally
    logic [STAGES-2:0] o_tw_index;
    logic [N-1:0]      i_tw_re;
    logic [N-1:0]      i_tw_im;

    // bin output stream
    logic              o_out_valid;
    logic              i_out_ready;
    logic [N-1:0]      o_out_re;
    logic [N-1:0]      o_out_im;
    logic [STAGES-1:0] o_out_index;
    logic              o_out_last;

    // status
    logic              o_butterfly_done;
    logic              o_FFT_cycle_done;
    logic [STAGES-1:0] o_stage;

    // core side
    modport slave (
        input  i_in_valid, i_in_re, i_in_im,
        input  i_tw_re, i_tw_im,
        input  i_out_ready,
        output o_in_ready, o_tw_index,
        output o_out_valid, o_out_re, o_out_im, o_out_index, o_out_last,
        output o_butterfly_done, o_FFT_cycle_done, o_stage
    );

    // environment side
    modport master (
        output i_in_valid, i_in_re, i_in_im,
        output i_tw_re, i_tw_im,
        output i_out_ready,
        input  o_in_ready, o_tw_index,
        input  o_out_valid, o_out_re, o_out_im, o_out_index, o_out_last,
        input  o_butterfly_done, o_FFT_cycle_done, o_stage
    );
endinterface
`default_nettype wire

// File: rtl/fft_iter_core.sv
`default_nettype none
// ============================================================================
//  Module   : fft_iter_core
//  Purpose  : Iterative in-place radix-2 DIT FFT of 2^STAGES complex points.
//             Serial load (bit-reversed addressing), one butterfly per cycle,
//             serial natural-order unload with valid/ready backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module fft_iter_core #(
    parameter int N      = 16,
    parameter int Q      = 8,
    parameter int STAGES = 4,
    parameter int SCALE  = 1
) (
    input  wire logic i_clk,
    input  wire logic i_rst,
    fft_iter_if.slave bus
);

    localparam int c_p             = 1 << STAGES;
    localparam int c_last_stage_i  = STAGES - 1;

    localparam logic [STAGES-1:0] c_last_idx   = {STAGES{1'b1}};
    localparam logic [STAGES-2:0] c_last_bfly  = {(STAGES-1){1'b1}};
    localparam logic [STAGES-1:0] c_last_stage = c_last_stage_i[STAGES-1:0];
    localparam logic [STAGES-1:0] c_one        = {{(STAGES-1){1'b0}}, 1'b1};

    // saturation bounds at the three widths used in the datapath
    localparam logic signed [N-1:0] c_out_max  = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] c_out_min  = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [N:0]   c_nar_max  = {2'b00, {(N-1){1'b1}}};
    localparam logic signed [N:0]   c_nar_min  = {2'b11, {(N-1){1'b0}}};
    localparam logic signed [2*N:0] c_wide_max = {{(N+2){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [2*N:0] c_wide_min = {{(N+2){1'b1}}, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } state_t;

    // clamp a 2N+1 bit product sum to the N-bit sample range
    function automatic logic signed [N-1:0] sat_wide(input logic signed [2*N:0] v);
        if (v > c_wide_max)
            sat_wide = c_out_max;
        else if (v < c_wide_min)
            sat_wide = c_out_min;
        else
            sat_wide = v[N-1:0];
    endfunction

    // clamp an N+1 bit butterfly sum to the N-bit sample range
    function automatic logic signed [N-1:0] sat_nar(input logic signed [N:0] v);
        if (v > c_nar_max)
            sat_nar = c_out_max;
        else if (v < c_nar_min)
            sat_nar = c_out_min;
        else
            sat_nar = v[N-1:0];
    endfunction

    // sign-extend a sample to the full product width before multiplying
    function automatic logic signed [2*N-1:0] sext2(input logic signed [N-1:0] v);
        sext2 = {{N{v[N-1]}}, v};
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;

    logic signed [N-1:0] r_buf_re [c_p];
    logic signed [N-1:0] r_buf_im [c_p];

    logic [STAGES-1:0] r_load_cnt;
    logic [STAGES-1:0] r_out_idx;
    logic [STAGES-1:0] r_stage;
    logic [STAGES-2:0] r_bfly;
    logic              r_bfly_done;
    logic              r_cycle_done;

    logic              w_in_hs;
    logic              w_out_hs;
    logic              w_bfly_we;
    logic              w_last_bfly;

    logic [STAGES-1:0] w_bitrev;
    logic [STAGES-1:0] w_half;
    logic [STAGES-1:0] w_mask;
    logic [STAGES-1:0] w_j;
    logic [STAGES-1:0] w_addr_a;
    logic [STAGES-1:0] w_addr_c;
    logic [STAGES-1:0] w_tw_shift;
    logic [STAGES-2:0] w_tw_index;

    logic signed [N-1:0]   w_a_re, w_a_im, w_b_re, w_b_im, w_tw_re, w_tw_im;
    logic signed [2*N-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
    logic signed [2*N:0]   w_t_re_full, w_t_im_full, w_t_re_sh, w_t_im_sh;
    logic signed [N-1:0]   w_t_re, w_t_im;
    logic signed [N:0]     w_sum_re, w_sum_im, w_dif_re, w_dif_im;
    logic signed [N:0]     w_sum_re_sh, w_sum_im_sh, w_dif_re_sh, w_dif_im_sh;
    logic signed [N-1:0]   w_new_a_re, w_new_a_im, w_new_c_re, w_new_c_im;

    // load address is the bit-reversed sample count, so output comes out in natural order
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_bitrev
        assign w_bitrev[gi] = r_load_cnt[STAGES-1-gi];
    end

    // butterfly addressing and twiddle index for the current stage/butterfly
    always_comb begin
        w_half     = c_one << r_stage;
        w_mask     = w_half - c_one;
        w_j        = {1'b0, r_bfly} & w_mask;
        w_addr_a   = (({1'b0, r_bfly} & ~w_mask) << 1) | w_j;
        w_addr_c   = w_addr_a | w_half;
        w_tw_shift = c_last_stage - r_stage;
        w_tw_index = w_j[STAGES-2:0] << w_tw_shift;
    end

    // butterfly datapath: t = B*W rescaled, then A+t / A-t with optional halving
    always_comb begin
        w_a_re  = r_buf_re[w_addr_a];
        w_a_im  = r_buf_im[w_addr_a];
        w_b_re  = r_buf_re[w_addr_c];
        w_b_im  = r_buf_im[w_addr_c];
        w_tw_re = $signed(bus.i_tw_re);
        w_tw_im = $signed(bus.i_tw_im);

        w_p_rr = sext2(w_b_re) * sext2(w_tw_re);
        w_p_ii = sext2(w_b_im) * sext2(w_tw_im);
        w_p_ri = sext2(w_b_re) * sext2(w_tw_im);
        w_p_ir = sext2(w_b_im) * sext2(w_tw_re);

        w_t_re_full = {w_p_rr[2*N-1], w_p_rr} - {w_p_ii[2*N-1], w_p_ii};
        w_t_im_full = {w_p_ri[2*N-1], w_p_ri} + {w_p_ir[2*N-1], w_p_ir};
        w_t_re_sh   = w_t_re_full >>> Q;
        w_t_im_sh   = w_t_im_full >>> Q;
        w_t_re      = sat_wide(w_t_re_sh);
        w_t_im      = sat_wide(w_t_im_sh);

        w_sum_re = {w_a_re[N-1], w_a_re} + {w_t_re[N-1], w_t_re};
        w_sum_im = {w_a_im[N-1], w_a_im} + {w_t_im[N-1], w_t_im};
        w_dif_re = {w_a_re[N-1], w_a_re} - {w_t_re[N-1], w_t_re};
        w_dif_im = {w_a_im[N-1], w_a_im} - {w_t_im[N-1], w_t_im};

        w_sum_re_sh = w_sum_re >>> SCALE;
        w_sum_im_sh = w_sum_im >>> SCALE;
        w_dif_re_sh = w_dif_re >>> SCALE;
        w_dif_im_sh = w_dif_im >>> SCALE;

        w_new_a_re = sat_nar(w_sum_re_sh);
        w_new_a_im = sat_nar(w_sum_im_sh);
        w_new_c_re = sat_nar(w_dif_re_sh);
        w_new_c_im = sat_nar(w_dif_im_sh);
    end

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= ST_LOAD;
        else
            r_state <= w_state_nxt;
    end

    // next-state decode, handshake qualification and stream outputs
    always_comb begin
        w_state_nxt          = r_state;
        w_in_hs              = 1'b0;
        w_out_hs             = 1'b0;
        w_bfly_we            = 1'b0;
        w_last_bfly          = 1'b0;
        bus.o_in_ready       = 1'b0;
        bus.o_out_valid      = 1'b0;
        bus.o_out_re         = '0;
        bus.o_out_im         = '0;
        bus.o_out_last       = 1'b0;
        bus.o_tw_index       = '0;
        bus.o_out_index      = r_out_idx;
        bus.o_stage          = r_stage;
        bus.o_butterfly_done = r_bfly_done;
        bus.o_FFT_cycle_done = r_cycle_done;

        case (r_state)
            ST_LOAD: begin
                bus.o_in_ready = 1'b1;
                w_in_hs        = bus.i_in_valid;
                if (w_in_hs && (r_load_cnt == c_last_idx))
                    w_state_nxt = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                w_bfly_we      = 1'b1;
                bus.o_tw_index = w_tw_index;
                if ((r_stage == c_last_stage) && (r_bfly == c_last_bfly)) begin
                    w_last_bfly = 1'b1;
                    w_state_nxt = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                bus.o_out_valid = 1'b1;
                bus.o_out_re    = r_buf_re[r_out_idx];
                bus.o_out_im    = r_buf_im[r_out_idx];
                bus.o_out_last  = (r_out_idx == c_last_idx);
                w_out_hs        = bus.i_out_ready;
                if (w_out_hs && (r_out_idx == c_last_idx))
                    w_state_nxt = ST_LOAD;
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    // load/butterfly/stage/unload counters and the status pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_load_cnt   <= '0;
            r_out_idx    <= '0;
            r_stage      <= '0;
            r_bfly       <= '0;
            r_bfly_done  <= 1'b0;
            r_cycle_done <= 1'b0;
        end else begin
            r_bfly_done  <= w_bfly_we;
            r_cycle_done <= w_last_bfly;
            if (w_in_hs)
                r_load_cnt <= r_load_cnt + 1'b1;
            if (w_bfly_we) begin
                r_bfly <= r_bfly + 1'b1;
                if (r_bfly == c_last_bfly)
                    r_stage <= w_last_bfly ? '0 : r_stage + 1'b1;
            end
            if (w_out_hs)
                r_out_idx <= r_out_idx + 1'b1;
        end
    end

    // sample buffer: written by the input stream or by the butterfly, never cleared
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_in_hs) begin
                r_buf_re[w_bitrev] <= $signed(bus.i_in_re);
                r_buf_im[w_bitrev] <= $signed(bus.i_in_im);
            end else if (w_bfly_we) begin
                r_buf_re[w_addr_a] <= w_new_a_re;
                r_buf_im[w_addr_a] <= w_new_a_im;
                r_buf_re[w_addr_c] <= w_new_c_re;
                r_buf_im[w_addr_c] <= w_new_c_im;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_iter_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_iter_core
//  Purpose  : Directed self-checking bench for fft_iter_core; two instances
//             (no scaling / per-stage halving) driven in lockstep.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fft_iter_core;

    localparam int N      = 16;
    localparam int STAGES = 4;
    localparam int P      = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [N-1:0] in_re = '0;
    logic [N-1:0] in_im = '0;

    logic signed [N-1:0] tw_re_tab [8];
    logic signed [N-1:0] tw_im_tab [8];

    int fr_re [P];
    int fr_im [P];
    int exp0_re [P];
    int exp0_im [P];
    int exp1_re [P];
    int exp1_im [P];
    bit chk1;
    bit hold_valid;
    int hs_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fft_iter_if #(.N(N), .STAGES(STAGES)) bus0 ();
    fft_iter_if #(.N(N), .STAGES(STAGES)) bus1 ();

    assign bus0.i_in_valid  = in_valid;
    assign bus0.i_in_re     = in_re;
    assign bus0.i_in_im     = in_im;
    assign bus0.i_out_ready = out_ready;
    assign bus0.i_tw_re     = tw_re_tab[bus0.o_tw_index];
    assign bus0.i_tw_im     = tw_im_tab[bus0.o_tw_index];
    assign bus1.i_in_valid  = in_valid;
    assign bus1.i_in_re     = in_re;
    assign bus1.i_in_im     = in_im;
    assign bus1.i_out_ready = out_ready;
    assign bus1.i_tw_re     = tw_re_tab[bus1.o_tw_index];
    assign bus1.i_tw_im     = tw_im_tab[bus1.o_tw_index];

    fft_iter_core #(.N(N), .Q(8), .STAGES(STAGES), .SCALE(0)) dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus0)
    );

    fft_iter_core #(.N(N), .Q(8), .STAGES(STAGES), .SCALE(1)) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"},  bus0.o_in_ready, 1);
        chk({tag, "_out_valid"}, bus0.o_out_valid, 0);
        chk({tag, "_out_last"},  bus0.o_out_last, 0);
        chk({tag, "_bfly_done"}, bus0.o_butterfly_done, 0);
        chk({tag, "_cycle_done"},bus0.o_FFT_cycle_done, 0);
        chk({tag, "_stage"},     bus0.o_stage, 0);
        chk({tag, "_tw_index"},  bus0.o_tw_index, 0);
        chk({tag, "_out_index"}, bus0.o_out_index, 0);
        chk({tag, "_out_re"},    $signed(bus0.o_out_re), 0);
        chk({tag, "_out_im"},    $signed(bus0.o_out_im), 0);
        chk({tag, "_in_ready1"}, bus1.o_in_ready, 1);
    endtask

    task automatic clear_frame();
        for (int i = 0; i < P; i++) begin
            fr_re[i] = 0; fr_im[i] = 0;
            exp0_re[i] = 0; exp0_im[i] = 0; exp1_re[i] = 0; exp1_im[i] = 0;
        end
        hs_cnt = 0;
    endtask

    task automatic load_frame(input int gap);
        int  i = 0;
        int  cyc = 0;
        bit  hs;
        while (i < P && cyc < 400) begin
            @(negedge clk);
            in_valid = (cyc % gap == 0);
            in_re    = N'(fr_re[i]);
            in_im    = N'(fr_im[i]);
            hs       = in_valid && bus0.o_in_ready;
            @(posedge clk);
            if (hs) begin
                i++;
                hs_cnt++;
            end
            cyc++;
        end
        chk("load_count", i, P);
    endtask

    // waits for the end-of-transform pulse; leaves the caller at that negedge
    task automatic wait_done();
        int k = 0;
        int nb = 0;
        bit seen = 0;
        while (!seen && k < 100) begin
            @(negedge clk);
            in_valid = hold_valid;
            if (in_valid && bus0.o_in_ready) hs_cnt++;
            if (bus0.o_butterfly_done) nb++;
            if (k == 9) begin
                chk("stage_at_9", bus0.o_stage, 1);
                chk("tw_index_at_9", bus0.o_tw_index, 4);
                chk("in_ready_compute", bus0.o_in_ready, 0);
            end
            if (bus0.o_FFT_cycle_done) begin
                seen = 1;
            end else begin
                @(posedge clk);
                k++;
            end
        end
        chk("done_latency", k, 32);
        chk("bfly_pulses", nb, 32);
        chk("done_dut1", bus1.o_FFT_cycle_done, 1);
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0,1. Stops when bin abort_at is presented.
    task automatic unload(input int mode, input int abort_at);
        int nbin = 0;
        int cyc  = 0;
        while (nbin < P && cyc < 200) begin
            if (cyc > 0) @(negedge clk);
            if (nbin == abort_at) begin
                out_ready = 1'b0;
                break;
            end
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            in_valid  = hold_valid && !(out_ready && nbin == P-1);
            if (in_valid && bus0.o_in_ready) hs_cnt++;
            if (cyc > 0) chk("done_single_pulse", bus0.o_FFT_cycle_done, 0);
            chk("out_valid", bus0.o_out_valid, 1);
            chk("out_index", bus0.o_out_index, nbin);
            chk("out_last",  bus0.o_out_last, (nbin == P-1));
            chk($sformatf("bin%0d_re_s0", nbin), $signed(bus0.o_out_re), exp0_re[nbin]);
            chk($sformatf("bin%0d_im_s0", nbin), $signed(bus0.o_out_im), exp0_im[nbin]);
            if (chk1) begin
                chk($sformatf("bin%0d_re_s1", nbin), $signed(bus1.o_out_re), exp1_re[nbin]);
                chk($sformatf("bin%0d_im_s1", nbin), $signed(bus1.o_out_im), exp1_im[nbin]);
            end
            @(posedge clk);
            if (out_ready) nbin++;
            cyc++;
        end
        if (abort_at >= P) begin
            chk("unload_count", nbin, P);
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            chk("post_in_ready",  bus0.o_in_ready, 1);
            chk("post_out_valid", bus0.o_out_valid, 0);
            chk("samples_taken",  hs_cnt, P);
        end
    endtask

    task automatic idle_watch(input int cycles);
        int np = 0;
        int nv = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus0.o_FFT_cycle_done || bus1.o_FFT_cycle_done || bus0.o_butterfly_done) np++;
            if (bus0.o_out_valid || !bus0.o_in_ready) nv++;
        end
        chk("abort_no_pulse", np, 0);
        chk("abort_idle", nv, 0);
    endtask

    task automatic set_impulse();
        clear_frame();
        fr_re[0] = 256;
        for (int i = 0; i < P; i++) begin
            exp0_re[i] = 256;
            exp1_re[i] = 16;
        end
        chk1 = 1;
    endtask

    initial begin
        tw_re_tab[0] = 16'sd256;  tw_im_tab[0] = 16'sd0;
        tw_re_tab[1] = 16'sd237;  tw_im_tab[1] = -16'sd98;
        tw_re_tab[2] = 16'sd181;  tw_im_tab[2] = -16'sd181;
        tw_re_tab[3] = 16'sd98;   tw_im_tab[3] = -16'sd237;
        tw_re_tab[4] = 16'sd0;    tw_im_tab[4] = -16'sd256;
        tw_re_tab[5] = -16'sd98;  tw_im_tab[5] = -16'sd237;
        tw_re_tab[6] = -16'sd181; tw_im_tab[6] = -16'sd181;
        tw_re_tab[7] = -16'sd237; tw_im_tab[7] = -16'sd98;
        hold_valid = 0;
        chk1 = 0;

        apply_reset();
        check_idle("reset");

        // impulse: flat spectrum, 1/16 of it with per-stage halving
        set_impulse();
        load_frame(1);
        wait_done();
        unload(0, P);

        // two samples: bins j and j+8 are 256 +/- 256*W^j; under backpressure
        clear_frame();
        fr_re[0] = 256; fr_re[1] = 256;
        for (int j = 0; j < 8; j++) begin
            exp0_re[j]   = 256 + int'(tw_re_tab[j]);
            exp0_im[j]   = int'(tw_im_tab[j]);
            exp0_re[j+8] = 256 - int'(tw_re_tab[j]);
            exp0_im[j+8] = -int'(tw_im_tab[j]);
        end
        chk1 = 0;
        load_frame(1);
        wait_done();
        unload(1, P);

        // DC 256, sparse input valid: everything lands in bin 0
        clear_frame();
        for (int i = 0; i < P; i++) fr_re[i] = 256;
        exp0_re[0] = 4096;
        exp1_re[0] = 256;
        chk1 = 1;
        load_frame(3);
        wait_done();
        unload(0, P);

        // DC 4096 saturates without scaling; input valid held through compute/unload
        clear_frame();
        for (int i = 0; i < P; i++) fr_re[i] = 4096;
        exp0_re[0] = 32767;
        exp1_re[0] = 4096;
        chk1 = 1;
        hold_valid = 1;
        load_frame(1);
        wait_done();
        unload(1, P);
        hold_valid = 0;

        // reset ten cycles into the transform
        set_impulse();
        load_frame(1);
        repeat (10) @(posedge clk);
        apply_reset();
        check_idle("rst_compute");
        idle_watch(40);

        // reset while bin 5 is presented
        set_impulse();
        load_frame(1);
        wait_done();
        unload(0, 5);
        apply_reset();
        check_idle("rst_unload");
        idle_watch(10);

        // fresh frame after the aborts
        set_impulse();
        load_frame(1);
        wait_done();
        unload(0, P);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
